// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO responder.
package mdio_pkg;

  typedef enum logic [2:0] {
    IDLE, ST2, OP, PHYAD, REGAD, TA, DATA, SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  // Bits still owed by the master after a PHYAD mismatch: REGAD, TA, DATA.
  localparam int SKIP_BITS = REGAD_W + 2 + DATA_W;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronizes mdc/mdio into the clock domain and flags rising mdc edges.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mdc_q      <= '0;
      mdio_q     <= '1;
      mdc_prev_q <= 1'b0;
    end else begin
      mdc_q      <= {mdc_q[SYNC_STAGES-2:0], mdc};
      mdio_q     <= {mdio_q[SYNC_STAGES-2:0], mdio_i};
      mdc_prev_q <= mdc_q[SYNC_STAGES-1];
    end
  end

  // Equal-depth chains keep mdio_s aligned with the detected edge.
  assign mdc_rise = mdc_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign mdio_s   = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder: decodes frames on sampled mdc rising
// edges and serves reads/writes through a one-cycle register-bank port.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
  parameter int                 PREAMBLE_MIN = 32,
  parameter int                 SYNC_STAGES  = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mdc,
  input  logic               mdio_i,
  output logic               mdio_o,
  output logic               mdio_oe,
  output logic [REGAD_W-1:0] reg_addr,
  output logic               reg_rd_en,
  input  logic [DATA_W-1:0]  reg_rd_data,
  output logic               reg_wr_en,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic               frame_err
);

  localparam int            PW      = $clog2(PREAMBLE_MIN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_MIN);

  logic mdc_rise, mdio_s;

  mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock    (clock),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  mdio_state_e          state_q;
  logic [PW-1:0]        pre_q;
  logic [4:0]           cnt_q;
  logic [DATA_W-1:0]    sh_q;
  logic                 rd_q;
  logic                 cap_q;
  logic                 oe_q, o_q, rd_en_q, wr_en_q, err_q;
  logic [REGAD_W-1:0]   addr_q;
  logic [DATA_W-1:0]    wr_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rd_q      <= 1'b0;
      cap_q     <= 1'b0;
      oe_q      <= 1'b0;
      o_q       <= 1'b1;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      cap_q   <= rd_en_q;
      if (mdc_rise) begin
        case (state_q)
          IDLE: begin
            if (mdio_s) begin
              if (pre_q != PRE_MAX) pre_q <= pre_q + 1'b1;
            end else begin
              // This 0 is the first ST bit only after a full preamble.
              if (pre_q == PRE_MAX) state_q <= ST2;
              pre_q <= '0;
            end
          end
          ST2: begin
            cnt_q <= '0;
            if (mdio_s) begin
              state_q <= OP;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
          OP: begin
            if (cnt_q == 5'd0) begin
              sh_q  <= {sh_q[DATA_W-2:0], mdio_s};
              cnt_q <= 5'd1;
            end else begin
              cnt_q <= '0;
              if ({sh_q[0], mdio_s} == OP_READ) begin
                rd_q    <= 1'b1;
                state_q <= PHYAD;
              end else if ({sh_q[0], mdio_s} == OP_WRITE) begin
                rd_q    <= 1'b0;
                state_q <= PHYAD;
              end else begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          PHYAD: begin
            sh_q <= {sh_q[DATA_W-2:0], mdio_s};
            if (cnt_q == 5'(PHYAD_W - 1)) begin
              cnt_q   <= '0;
              state_q <= ({sh_q[PHYAD_W-2:0], mdio_s} == PHY_ADDR) ? REGAD : SKIP;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          REGAD: begin
            sh_q <= {sh_q[DATA_W-2:0], mdio_s};
            if (cnt_q == 5'(REGAD_W - 1)) begin
              addr_q  <= {sh_q[REGAD_W-2:0], mdio_s};
              rd_en_q <= rd_q;
              cnt_q   <= '0;
              state_q <= TA;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          TA: begin
            // Reads drive the second TA bit low; writes let the master own both.
            if (rd_q) begin
              oe_q    <= 1'b1;
              o_q     <= 1'b0;
              cnt_q   <= '0;
              state_q <= DATA;
            end else if (cnt_q == 5'd1) begin
              cnt_q   <= '0;
              state_q <= DATA;
            end else begin
              cnt_q <= 5'd1;
            end
          end
          DATA: begin
            if (rd_q) begin
              if (cnt_q == 5'(DATA_W)) begin
                oe_q    <= 1'b0;
                o_q     <= 1'b1;
                state_q <= IDLE;
              end else begin
                o_q   <= sh_q[DATA_W-1];
                sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
                cnt_q <= cnt_q + 5'd1;
              end
            end else begin
              sh_q <= {sh_q[DATA_W-2:0], mdio_s};
              if (cnt_q == 5'(DATA_W - 1)) begin
                wr_data_q <= {sh_q[DATA_W-2:0], mdio_s};
                wr_en_q   <= 1'b1;
                state_q   <= IDLE;
              end else begin
                cnt_q <= cnt_q + 5'd1;
              end
            end
          end
          SKIP: begin
            if (cnt_q == 5'(SKIP_BITS - 1)) state_q <= IDLE;
            else                            cnt_q   <= cnt_q + 5'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
      // Bank data arrives long before the next mdc edge, so this never races a shift.
      if (cap_q) sh_q <= reg_rd_data;
    end
  end

  assign mdio_o      = o_q;
  assign mdio_oe     = oe_q;
  assign reg_addr    = addr_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a bit-banged station manager drives frames and a
// frame-level outcome model plus register-bank shadow supplies expectations.
module tb_mdio_responder;

  localparam int         HALF    = 5;
  localparam int         PRE_MIN = 32;
  localparam logic [4:0] MY_ADDR = 5'd1;

  logic        clock = 1'b0, reset = 1'b1, mdc = 1'b0, mdio_drv = 1'b1;
  logic        mdio_i, mdio_o, mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd_en, reg_wr_en, frame_err;
  logic [15:0] reg_rd_data, reg_wr_data;

  // Shared bus line: responder wins when driving, else the master / pull-up.
  assign mdio_i = mdio_oe ? mdio_o : mdio_drv;

  always #5 clock = ~clock;

  mdio_responder #(.PHY_ADDR(MY_ADDR), .PREAMBLE_MIN(PRE_MIN), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .frame_err(frame_err)
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 2) ? 16'h0141 : 16'(16'hA500 + i * 16'h0013);
  endfunction

  logic [15:0] bank  [32];
  logic [15:0] mregs [32];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
      reg_rd_data <= '0;
    end else begin
      if (reg_rd_en) reg_rd_data <= bank[reg_addr];
      if (reg_wr_en) bank[reg_addr] <= reg_wr_data;
    end
  end

  int          rd_n = 0, wr_n = 0, err_n = 0, oe_n = 0;
  logic [4:0]  rd_addr_l = '0, wr_addr_l = '0;
  logic [15:0] wr_data_l = '0;

  always @(posedge clock) begin
    if (reg_rd_en) begin rd_n <= rd_n + 1; rd_addr_l <= reg_addr; end
    if (reg_wr_en) begin wr_n <= wr_n + 1; wr_addr_l <= reg_addr; wr_data_l <= reg_wr_data; end
    if (frame_err) err_n <= err_n + 1;
    if (mdio_oe)   oe_n  <= oe_n + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One MDIO bit: master sets the line, samples it just before raising mdc.
  task automatic mdc_bit(input logic b, output logic s);
    mdio_drv = b;
    repeat (HALF) @(negedge clock);
    s   = mdio_i;
    mdc = 1'b1;
    repeat (HALF) @(negedge clock);
    mdc = 1'b0;
  endtask

  task automatic send_field(input logic [15:0] v, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) mdc_bit(v[i], s);
  endtask

  // 0 = ignored, 1 = read served, 2 = write served, 3 = frame error.
  function automatic int model(input int pre, input logic [1:0] st, input logic [1:0] op,
                               input logic [4:0] pa);
    if (pre < PRE_MIN)                      return 0;
    if (st != 2'b01)                        return 3;
    if (op != 2'b10 && op != 2'b01)         return 3;
    if (pa != MY_ADDR)                      return 0;
    return (op == 2'b10) ? 1 : 2;
  endfunction

  task automatic run_frame(input string tag, input int pre, input logic [1:0] st,
                           input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input int kind);
    int r0, w0, e0, o0;
    logic s, ta_s, rel;
    logic [15:0] rd_s;
    r0 = rd_n; w0 = wr_n; e0 = err_n; o0 = oe_n;
    rel  = (op == 2'b10);
    ta_s = 1'b1;
    rd_s = '0;
    // Leading 0 clears any partial preamble left by an ignored frame's tail.
    mdc_bit(1'b0, s);
    repeat (pre) mdc_bit(1'b1, s);
    send_field(16'(st), 2);
    send_field(16'(op), 2);
    send_field(16'(pa), 5);
    send_field(16'(ra), 5);
    if (rel) begin mdc_bit(1'b1, s); mdc_bit(1'b1, ta_s); end
    else     begin mdc_bit(1'b1, s); mdc_bit(1'b0, s);    end
    for (int i = 15; i >= 0; i--) begin
      mdc_bit(rel ? 1'b1 : wd[i], s);
      rd_s[i] = s;
    end
    mdio_drv = 1'b1;
    repeat (6) @(negedge clock);
    chk($sformatf("%s rd_en pulses", tag), 32'(rd_n - r0), 32'(kind == 1));
    chk($sformatf("%s wr_en pulses", tag), 32'(wr_n - w0), 32'(kind == 2));
    chk($sformatf("%s frame_err pulses", tag), 32'(err_n - e0), 32'(kind == 3));
    chk($sformatf("%s drove bus", tag), 32'(oe_n != o0), 32'(kind == 1));
    chk($sformatf("%s bus released", tag), {30'd0, mdio_oe, mdio_o}, 32'b01);
    if (kind == 1) begin
      chk($sformatf("%s rd addr", tag), 32'(rd_addr_l), 32'(ra));
      chk($sformatf("%s TA bit", tag), 32'(ta_s), 32'd0);
      chk($sformatf("%s rd data", tag), 32'(rd_s), 32'(mregs[ra]));
    end
    if (kind == 2) begin
      chk($sformatf("%s wr addr", tag), 32'(wr_addr_l), 32'(ra));
      chk($sformatf("%s wr data", tag), 32'(wr_data_l), 32'(wd));
      mregs[ra] = wd;
    end
  endtask

  typedef struct {
    int         pre;
    logic [1:0] st, op;
    logic [4:0] pa, ra;
    logic [15:0] wd;
    int         kind;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    int pre, k;
    logic [1:0] st, op;
    logic [4:0] pa, ra;
    logic [15:0] wd;

    tbl[0]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  16'h0000, 1};
    tbl[1]  = '{32, 2'b01, 2'b01, 5'd1, 5'd0,  16'h8000, 2};
    tbl[2]  = '{32, 2'b01, 2'b10, 5'd5, 5'd2,  16'h0000, 0};
    tbl[3]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  16'h0000, 1};
    tbl[4]  = '{20, 2'b01, 2'b10, 5'd1, 5'd2,  16'h0000, 0};
    tbl[5]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  16'h0000, 1};
    tbl[6]  = '{32, 2'b01, 2'b11, 5'd1, 5'd2,  16'h0000, 3};
    tbl[7]  = '{32, 2'b00, 2'b10, 5'd1, 5'd2,  16'h0000, 3};
    tbl[8]  = '{32, 2'b01, 2'b10, 5'd1, 5'd0,  16'h0000, 1};
    tbl[9]  = '{31, 2'b01, 2'b10, 5'd1, 5'd4,  16'h0000, 0};
    tbl[10] = '{40, 2'b01, 2'b01, 5'd1, 5'd31, 16'hFFFF, 2};
    tbl[11] = '{32, 2'b01, 2'b00, 5'd1, 5'd3,  16'h0000, 3};

    for (int i = 0; i < 32; i++) mregs[i] = init_val(i);

    repeat (3) @(negedge clock);
    chk("reset mdio_oe", 32'(mdio_oe), 32'd0);
    chk("reset mdio_o", 32'(mdio_o), 32'd1);
    chk("reset strobes", {29'd0, reg_rd_en, reg_wr_en, frame_err}, 32'd0);
    chk("reset reg_addr", 32'(reg_addr), 32'd0);
    chk("reset reg_wr_data", 32'(reg_wr_data), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 12; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].pre, tbl[i].st, tbl[i].op,
                tbl[i].pa, tbl[i].ra, tbl[i].wd, tbl[i].kind);

    // Reset in the middle of a read's data phase (after data bit 8).
    mdc_bit(1'b0, s);
    repeat (32) mdc_bit(1'b1, s);
    send_field(16'b01, 2);
    send_field(16'b10, 2);
    send_field(16'(MY_ADDR), 5);
    send_field(16'd3, 5);
    mdc_bit(1'b1, s); mdc_bit(1'b1, s);
    repeat (8) mdc_bit(1'b1, s);
    chk("midrst driving before reset", 32'(mdio_oe), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst mdio_oe same clock", 32'(mdio_oe), 32'd0);
    chk("midrst mdio_o same clock", 32'(mdio_o), 32'd1);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = init_val(i);
    repeat (3) @(negedge clock);
    run_frame("post-reset read3", 32, 2'b01, 2'b10, MY_ADDR, 5'd3, 16'h0000, 1);

    for (int n = 0; n < 28; n++) begin
      case ($urandom_range(0, 4))
        0:       pre = 20;
        1:       pre = 31;
        2:       pre = 32;
        3:       pre = 33;
        default: pre = 40;
      endcase
      st = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      op = 2'($urandom);
      pa = ($urandom_range(0, 2) != 0) ? MY_ADDR : 5'($urandom);
      ra = 5'($urandom);
      wd = 16'($urandom);
      k  = model(pre, st, op, pa);
      run_frame($sformatf("rnd%0d", n), pre, st, op, pa, ra, wd, k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
